lsu_ctrl: RTL and testbench

//  Multi-cycle load/store unit; successor to the combinational MEM-stage RAM access.

---
 rtl/lsu_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store unit for the MEM stage.
//  Accepts one load/store per req_valid_i/req_ready_o handshake, runs it on a
//  req/gnt/rvalid data bus and returns extended load data plus exception flags
//  as a one-cycle resp_valid_o pulse.
// Ports:
//  clk, rst_n                 clock, asynchronous active-low reset
//  flush_i                    kill the current or incoming access
//  req_valid_i / req_ready_o  request handshake (ready only in IDLE)
//  ld_st_info_i               one-hot lb/lh/lw/ld/lbu/lhu/lwu/sb/sh/sw/sd
//  addr_i, wdata_i            byte address, LSB-justified store data
//  resp_valid_o, rdata_o      response pulse and extended load data
//  ld/st_misalign_o, ld/st_bus_err_o  exception flags, valid with resp_valid_o
//  bus_*                      data bus master (word-aligned addr, byte enables)
// Build option:
//  LSU_MISALIGN_SPLIT_EN      misaligned accesses run as two bus beats instead
//                             of being rejected with a misalign flag.
module lsu_ctrl #(
  parameter  int unsigned XLEN             = 64,
  localparam int unsigned LD_ST_INFO_WIDTH = 11,
  localparam int unsigned BE_W             = XLEN / 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [LD_ST_INFO_WIDTH-1:0] ld_st_info_i,
  input  logic [XLEN-1:0]             addr_i,
  input  logic [XLEN-1:0]             wdata_i,
  output logic                        resp_valid_o,
  output logic [XLEN-1:0]             rdata_o,
  output logic                        ld_misalign_o,
  output logic                        st_misalign_o,
  output logic                        ld_bus_err_o,
  output logic                        st_bus_err_o,
  output logic                        bus_req_o,
  output logic                        bus_we_o,
  output logic [XLEN-1:0]             bus_addr_o,
  output logic [BE_W-1:0]             bus_be_o,
  output logic [XLEN-1:0]             bus_wdata_o,
  input  logic                        bus_gnt_i,
  input  logic                        bus_rvalid_i,
  input  logic [XLEN-1:0]             bus_rdata_i,
  input  logic                        bus_err_i
);

  localparam int unsigned OFF_W = $clog2(BE_W);

  // One-hot positions in ld_st_info_i
  localparam int unsigned LD_B  = 0;
  localparam int unsigned LD_H  = 1;
  localparam int unsigned LD_W  = 2;
  localparam int unsigned LD_D  = 3;
  localparam int unsigned LD_BU = 4;
  localparam int unsigned LD_HU = 5;
  localparam int unsigned LD_WU = 6;
  localparam int unsigned ST_B  = 7;
  localparam int unsigned ST_H  = 8;
  localparam int unsigned ST_W  = 9;
  localparam int unsigned ST_D  = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_e;

  // Access size: 0 byte, 1 half, 2 word, 3 double
  function automatic logic [1:0] op_size(input logic [LD_ST_INFO_WIDTH-1:0] op);
    logic [1:0] sz;
    sz = 2'd0;
    if (op[LD_D] | op[ST_D])                   sz = 2'd3;
    else if (op[LD_W] | op[LD_WU] | op[ST_W])  sz = 2'd2;
    else if (op[LD_H] | op[LD_HU] | op[ST_H])  sz = 2'd1;
    else if (op[LD_B] | op[LD_BU] | op[ST_B])  sz = 2'd0;
    return sz;
  endfunction

  function automatic logic [BE_W-1:0] size_mask(input logic [1:0] sz);
    logic [BE_W-1:0] m;
    case (sz)
      2'd0:    m = BE_W'(1);
      2'd1:    m = BE_W'(3);
      2'd2:    m = BE_W'(15);
      default: m = '1;
    endcase
    return m;
  endfunction

  // Store data copied into every lane of its size
  function automatic logic [XLEN-1:0] rep_data(input logic [1:0] sz, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    case (sz)
      2'd0:    r = {BE_W{d[7:0]}};
      2'd1:    r = {(BE_W/2){d[15:0]}};
      2'd2:    r = {(BE_W/4){d[31:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [OFF_W-1:0] off);
    logic m;
    case (sz)
      2'd0:    m = 1'b0;
      2'd1:    m = off[0];
      2'd2:    m = (off[1:0] != 2'd0);
      default: m = (off != '0);
    endcase
    return m;
  endfunction

  state_e                      state_q, state_d;
  logic [LD_ST_INFO_WIDTH-1:0] op_q, op_d;
  logic [OFF_W-1:0]            off_q, off_d;
  logic                        split_q, split_d;
  logic                        flushed_q, flushed_d;
  logic [XLEN-1:0]             beat0_q, beat0_d;
  logic [XLEN-1:0]             addr1_q, addr1_d;
  logic [BE_W-1:0]             be1_q, be1_d;
  logic [XLEN-1:0]             wdata1_q, wdata1_d;

  logic                        ready_d, resp_valid_d, bus_req_d, bus_we_d;
  logic [XLEN-1:0]             rdata_d, bus_addr_d, bus_wdata_d;
  logic [BE_W-1:0]             bus_be_d;
  logic                        ld_mis_d, st_mis_d, ld_err_d, st_err_d;

  // Incoming request decode
  logic [1:0]                  in_sz;
  logic [OFF_W-1:0]            in_off;
  logic                        in_store, in_mis;
  logic [XLEN-1:0]             in_addr_al, in_wd_rep;
  logic [2*BE_W-1:0]           in_be_wide;
  logic [2*XLEN-1:0]           in_wd_wide;

  assign in_sz      = op_size(ld_st_info_i);
  assign in_off     = addr_i[OFF_W-1:0];
  assign in_store   = |ld_st_info_i[ST_D:ST_B];
  assign in_mis     = misaligned(in_sz, in_off);
  assign in_addr_al = {addr_i[XLEN-1:OFF_W], OFF_W'(0)};
  assign in_wd_rep  = rep_data(in_sz, wdata_i);
  // Two-word window: low half is beat0, high half spills into beat1
  assign in_be_wide = {BE_W'(0), size_mask(in_sz)} << in_off;
  assign in_wd_wide = {XLEN'(0), wdata_i} << {in_off, 3'b000};

  // Load data alignment and extension
  logic                        is_store_q;
  logic [2*XLEN-1:0]           ld_wide;
  logic [XLEN-1:0]             ld_raw, ld_ext;

  assign is_store_q = |op_q[ST_D:ST_B];
  assign ld_wide    = split_q ? {bus_rdata_i, beat0_q} : {XLEN'(0), bus_rdata_i};
  assign ld_raw     = XLEN'(ld_wide >> {off_q, 3'b000});

  always_comb begin
    ld_ext = '0;
    if (op_q[LD_B])       ld_ext = {{(XLEN-8){ld_raw[7]}}, ld_raw[7:0]};
    else if (op_q[LD_H])  ld_ext = {{(XLEN-16){ld_raw[15]}}, ld_raw[15:0]};
    else if (op_q[LD_W])  ld_ext = {{(XLEN-32){ld_raw[31]}}, ld_raw[31:0]};
    else if (op_q[LD_BU]) ld_ext = {(XLEN-8)'(0), ld_raw[7:0]};
    else if (op_q[LD_HU]) ld_ext = {(XLEN-16)'(0), ld_raw[15:0]};
    else if (op_q[LD_WU]) ld_ext = {(XLEN-32)'(0), ld_raw[31:0]};
    else if (op_q[LD_D])  ld_ext = ld_raw;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    off_d        = off_q;
    split_d      = split_q;
    flushed_d    = flushed_q;
    beat0_d      = beat0_q;
    addr1_d      = addr1_q;
    be1_d        = be1_q;
    wdata1_d     = wdata1_q;
    bus_we_d     = bus_we_o;
    bus_addr_d   = bus_addr_o;
    bus_be_d     = bus_be_o;
    bus_wdata_d  = bus_wdata_o;
    rdata_d      = '0;
    ld_mis_d     = 1'b0;
    st_mis_d     = 1'b0;
    ld_err_d     = 1'b0;
    st_err_d     = 1'b0;
    ready_d      = 1'b0;
    resp_valid_d = 1'b0;
    bus_req_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // flush_i blocks a same-cycle request
        if (req_valid_i && !flush_i) begin
          op_d        = ld_st_info_i;
          off_d       = in_off;
          split_d     = 1'b0;
          flushed_d   = 1'b0;
          bus_we_d    = in_store;
          bus_addr_d  = in_addr_al;
          bus_be_d    = in_be_wide[BE_W-1:0];
          bus_wdata_d = in_mis ? in_wd_wide[XLEN-1:0] : in_wd_rep;
          addr1_d     = in_addr_al + XLEN'(BE_W);
          be1_d       = in_be_wide[2*BE_W-1:BE_W];
          wdata1_d    = in_wd_wide[2*XLEN-1:XLEN];
          if (in_mis) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            split_d = 1'b1;
            state_d = REQ0;
`else
            state_d  = RESP;
            ld_mis_d = !in_store;
            st_mis_d = in_store;
`endif
          end else begin
            state_d = REQ0;
          end
        end
      end

      REQ0, REQ1: begin
        // A granted beat must still be drained even if flushed this cycle
        if (bus_gnt_i) begin
          state_d   = (state_q == REQ0) ? WAIT0 : WAIT1;
          flushed_d = flush_i;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end

      WAIT0, WAIT1: begin
        flushed_d = flushed_q | flush_i;
        if (bus_rvalid_i) begin
          if (flushed_q || flush_i) begin
            state_d = IDLE;
          end else if (bus_err_i) begin
            state_d  = RESP;
            ld_err_d = !is_store_q;
            st_err_d = is_store_q;
          end else if (state_q == WAIT0 && split_q) begin
            state_d     = REQ1;
            beat0_d     = bus_rdata_i;
            bus_addr_d  = addr1_q;
            bus_be_d    = be1_q;
            bus_wdata_d = wdata1_q;
          end else begin
            state_d = RESP;
            rdata_d = is_store_q ? XLEN'(0) : ld_ext;
          end
        end
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    ready_d      = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    bus_req_d    = (state_d == REQ0) || (state_d == REQ1);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_q          <= '0;
      off_q         <= '0;
      split_q       <= 1'b0;
      flushed_q     <= 1'b0;
      beat0_q       <= '0;
      addr1_q       <= '0;
      be1_q         <= '0;
      wdata1_q      <= '0;
      req_ready_o   <= 1'b1;
      resp_valid_o  <= 1'b0;
      rdata_o       <= '0;
      ld_misalign_o <= 1'b0;
      st_misalign_o <= 1'b0;
      ld_bus_err_o  <= 1'b0;
      st_bus_err_o  <= 1'b0;
      bus_req_o     <= 1'b0;
      bus_we_o      <= 1'b0;
      bus_addr_o    <= '0;
      bus_be_o      <= '0;
      bus_wdata_o   <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      off_q         <= off_d;
      split_q       <= split_d;
      flushed_q     <= flushed_d;
      beat0_q       <= beat0_d;
      addr1_q       <= addr1_d;
      be1_q         <= be1_d;
      wdata1_q      <= wdata1_d;
      req_ready_o   <= ready_d;
      resp_valid_o  <= resp_valid_d;
      rdata_o       <= rdata_d;
      ld_misalign_o <= ld_mis_d;
      st_misalign_o <= st_mis_d;
      ld_bus_err_o  <= ld_err_d;
      st_bus_err_o  <= st_err_d;
      bus_req_o     <= bus_req_d;
      bus_we_o      <= bus_we_d;
      bus_addr_o    <= bus_addr_d;
      bus_be_o      <= bus_be_d;
      bus_wdata_o   <= bus_wdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl (XLEN=64).
//  Expected responses are queued when an access is issued and compared when
//  resp_valid_o pulses; bus-side fields are checked as each beat is served.
module tb_lsu_ctrl;

  localparam int unsigned XLEN = 64;
  localparam int LD_B  = 0;
  localparam int LD_H  = 1;
  localparam int LD_W  = 2;
  localparam int LD_D  = 3;
  localparam int LD_BU = 4;
  localparam int LD_HU = 5;
  localparam int LD_WU = 6;
  localparam int ST_B  = 7;
  localparam int ST_H  = 8;
  localparam int ST_W  = 9;
  localparam int ST_D  = 10;

  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFFEE_DDCC_BBAA_9988;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush_i;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [10:0]     ld_st_info_i;
  logic [XLEN-1:0] addr_i;
  logic [XLEN-1:0] wdata_i;
  logic            resp_valid_o;
  logic [XLEN-1:0] rdata_o;
  logic            ld_misalign_o, st_misalign_o, ld_bus_err_o, st_bus_err_o;
  logic            bus_req_o, bus_we_o;
  logic [XLEN-1:0] bus_addr_o, bus_wdata_o;
  logic [7:0]      bus_be_o;
  logic            bus_gnt_i, bus_rvalid_i, bus_err_i;
  logic [XLEN-1:0] bus_rdata_i;

  lsu_ctrl #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .ld_st_info_i  (ld_st_info_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .resp_valid_o  (resp_valid_o),
    .rdata_o       (rdata_o),
    .ld_misalign_o (ld_misalign_o),
    .st_misalign_o (st_misalign_o),
    .ld_bus_err_o  (ld_bus_err_o),
    .st_bus_err_o  (st_bus_err_o),
    .bus_req_o     (bus_req_o),
    .bus_we_o      (bus_we_o),
    .bus_addr_o    (bus_addr_o),
    .bus_be_o      (bus_be_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_gnt_i     (bus_gnt_i),
    .bus_rvalid_i  (bus_rvalid_i),
    .bus_rdata_i   (bus_rdata_i),
    .bus_err_i     (bus_err_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] rdata;
    logic [3:0]  flags;  // {ld_misalign, st_misalign, ld_bus_err, st_bus_err}
  } resp_t;

  resp_t sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid_o === 1'b1) begin : pop
      resp_t e;
      if (sb_q.size() == 0) begin
        check("unexpected_resp", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("resp_rdata", rdata_o, e.rdata);
        check("resp_flags", {ld_misalign_o, st_misalign_o, ld_bus_err_o, st_bus_err_o}, 64'(e.flags));
      end
    end
  end

  task automatic expect_resp(input logic [63:0] rd, input logic [3:0] flags);
    resp_t e;
    e.rdata = rd;
    e.flags = flags;
    sb_q.push_back(e);
  endtask

  task automatic issue(input int op, input logic [63:0] addr, input logic [63:0] wd);
    check("req_ready_before", req_ready_o, 64'd1);
    ld_st_info_i = 11'(1) << op;
    addr_i       = addr;
    wdata_i      = wd;
    req_valid_i  = 1'b1;
    step();
    req_valid_i  = 1'b0;
  endtask

  // Serve one bus beat: check the request, grant after gw cycles, then complete
  task automatic bus_beat(input logic [63:0] ea, input logic [7:0] ebe, input logic ewe,
                          input logic [63:0] elane, input int gw,
                          input logic [63:0] rd, input logic err);
    logic [63:0] m;
    int n;
    n = 0;
    while (bus_req_o !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    check("bus_req", bus_req_o, 64'd1);
    check("bus_addr", bus_addr_o, ea);
    check("bus_be", bus_be_o, ebe);
    check("bus_we", bus_we_o, ewe);
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{ebe[i]}};
    if (ewe) check("bus_wdata", bus_wdata_o & m, elane & m);
    repeat (gw) begin
      step();
      check("req_hold", bus_req_o, 64'd1);
      check("addr_hold", bus_addr_o, ea);
    end
    bus_gnt_i = 1'b1;
    step();
    bus_gnt_i = 1'b0;
    check("req_drop_after_gnt", bus_req_o, 64'd0);
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = rd;
    bus_err_i    = err;
    step();
    bus_rvalid_i = 1'b0;
    bus_err_i    = 1'b0;
  endtask

  // Single-beat access with full latency and response checks
  task automatic access(input int op, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [7:0] be, input logic [63:0] lane, input logic [63:0] rd,
                        input logic err, input int gw, input logic [63:0] exp_rd);
    logic st;
    st = (op >= ST_B);
    expect_resp(exp_rd, {2'b00, err & !st, err & st});
    issue(op, addr, wd);
    check("req_latency", bus_req_o, 64'd1);
    bus_beat({addr[63:3], 3'b000}, be, st, lane, gw, rd, err);
    check("resp_latency", resp_valid_o, 64'd1);
    step();
    check("ready_after_resp", req_ready_o, 64'd1);
    check("resp_one_cycle", resp_valid_o, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    flush_i      = 1'b0;
    req_valid_i  = 1'b0;
    ld_st_info_i = '0;
    addr_i       = '0;
    wdata_i      = '0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = '0;
    bus_err_i    = 1'b0;
    repeat (2) step();

    // Reset state
    check("rst_ready", req_ready_o, 64'd1);
    check("rst_bus_req", bus_req_o, 64'd0);
    check("rst_resp_valid", resp_valid_o, 64'd0);
    check("rst_rdata", rdata_o, 64'd0);
    check("rst_bus_addr", bus_addr_o, 64'd0);
    check("rst_bus_be", bus_be_o, 64'd0);
    check("rst_flags", {bus_we_o, ld_misalign_o, st_misalign_o, ld_bus_err_o, st_bus_err_o}, 64'd0);
    rst_n = 1'b1;
    step();

    // Aligned loads
    access(LD_B,  64'h1003, 64'h0, 8'h08, 64'h0, D0, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FF89);
    access(LD_BU, 64'h1003, 64'h0, 8'h08, 64'h0, D0, 1'b0, 1, 64'h0000_0000_0000_0089);
    access(LD_H,  64'h1002, 64'h0, 8'h0C, 64'h0, D0, 1'b0, 0, 64'hFFFF_FFFF_FFFF_89AB);
    access(LD_HU, 64'h1006, 64'h0, 8'hC0, 64'h0, D0, 1'b0, 2, 64'h0000_0000_0000_0123);
    access(LD_W,  64'h1000, 64'h0, 8'h0F, 64'h0, D0, 1'b0, 0, 64'hFFFF_FFFF_89AB_CDEF);
    access(LD_WU, 64'h1000, 64'h0, 8'h0F, 64'h0, D0, 1'b0, 0, 64'h0000_0000_89AB_CDEF);
    access(LD_W,  64'h1004, 64'h0, 8'hF0, 64'h0, D0, 1'b0, 0, 64'h0000_0000_0123_4567);
    access(LD_D,  64'h1008, 64'h0, 8'hFF, 64'h0, D1, 1'b0, 1, D1);

    // Aligned stores: response carries rdata 0 whatever the bus returns
    access(ST_H, 64'h2006, 64'h0000_0000_0000_BEEF, 8'hC0, 64'hBEEF_0000_0000_0000, D0, 1'b0, 0, 64'h0);
    access(ST_B, 64'h2007, 64'h0000_0000_0000_005A, 8'h80, 64'h5A00_0000_0000_0000, D0, 1'b0, 1, 64'h0);
    access(ST_W, 64'h2004, 64'h0000_0000_DEAD_BEEF, 8'hF0, 64'hDEAD_BEEF_0000_0000, D0, 1'b0, 0, 64'h0);
    access(ST_D, 64'h2000, 64'h1122_3344_5566_7788, 8'hFF, 64'h1122_3344_5566_7788, D0, 1'b0, 0, 64'h0);
    access(ST_B, 64'h2001, 64'hFFFF_FFFF_FFFF_FF11, 8'h02, 64'h0000_0000_0000_1100, D0, 1'b0, 0, 64'h0);

    // Bus errors
    access(LD_D, 64'h3000, 64'h0, 8'hFF, 64'h0, D0, 1'b1, 0, 64'h0);
    access(ST_D, 64'h3008, 64'h55, 8'hFF, 64'h55, D0, 1'b1, 0, 64'h0);

    // Misaligned accesses
`ifdef LSU_MISALIGN_SPLIT_EN
    expect_resp(64'hFFFF_FFFF_9988_0123, 4'b0000);
    issue(LD_W, 64'h1006, 64'h0);
    bus_beat(64'h1000, 8'hC0, 1'b0, 64'h0, 0, D0, 1'b0);
    bus_beat(64'h1008, 8'h03, 1'b0, 64'h0, 1, D1, 1'b0);
    check("split_resp", resp_valid_o, 64'd1);
    step();
    expect_resp(64'h0, 4'b0000);
    issue(ST_H, 64'h2007, 64'h0000_0000_0000_BEEF);
    bus_beat(64'h2000, 8'h80, 1'b1, 64'hEF00_0000_0000_0000, 0, D0, 1'b0);
    bus_beat(64'h2008, 8'h01, 1'b1, 64'h0000_0000_0000_00BE, 0, D0, 1'b0);
    check("split_st_resp", resp_valid_o, 64'd1);
    step();
`else
    begin
      int mops[4];
      logic [63:0] maddr[4];
      mops[0] = LD_W; maddr[0] = 64'h1006;
      mops[1] = ST_H; maddr[1] = 64'h2001;
      mops[2] = LD_D; maddr[2] = 64'h1004;
      mops[3] = ST_W; maddr[3] = 64'h2002;
      for (int k = 0; k < 4; k++) begin
        expect_resp(64'h0, (mops[k] >= ST_B) ? 4'b0100 : 4'b1000);
        issue(mops[k], maddr[k], 64'hFFFF);
        check("mis_no_bus_req", bus_req_o, 64'd0);
        check("mis_resp_next", resp_valid_o, 64'd1);
        step();
        check("mis_ready", req_ready_o, 64'd1);
        check("mis_still_no_req", bus_req_o, 64'd0);
      end
    end
`endif

    // flush_i wins over a same-cycle request
    flush_i = 1'b1;
    ld_st_info_i = 11'(1) << LD_D;
    addr_i = 64'h1000;
    req_valid_i = 1'b1;
    step();
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    check("flush_same_cycle_req", bus_req_o, 64'd0);
    check("flush_same_cycle_ready", req_ready_o, 64'd1);

    // Flush before grant: request drops, no response
    issue(LD_D, 64'h1000, 64'h0);
    check("flush_pre_req", bus_req_o, 64'd1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_pre_req_drop", bus_req_o, 64'd0);
    check("flush_pre_ready", req_ready_o, 64'd1);

    // Flush after grant: outstanding rvalid absorbed, no response
    issue(LD_D, 64'h1000, 64'h0);
    bus_gnt_i = 1'b1;
    step();
    bus_gnt_i = 1'b0;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_post_waiting", req_ready_o, 64'd0);
    step();
    check("flush_post_still_waiting", req_ready_o, 64'd0);
    bus_rvalid_i = 1'b1;
    bus_rdata_i = D0;
    step();
    bus_rvalid_i = 1'b0;
    check("flush_post_ready", req_ready_o, 64'd1);
    check("flush_post_no_resp", resp_valid_o, 64'd0);
    step();

    // Normal traffic resumes after flushes
    access(LD_B, 64'h1003, 64'h0, 8'h08, 64'h0, D0, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FF89);

    // Reset while requesting: bus_req_o drops at once
    issue(LD_D, 64'h1000, 64'h0);
    check("rst_req_pre", bus_req_o, 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_req_drop", bus_req_o, 64'd0);
    check("rst_req_ready", req_ready_o, 64'd1);
    step();
    rst_n = 1'b1;
    step();
    check("rst_req_release_ready", req_ready_o, 64'd1);

    // Reset during WAIT0
    issue(LD_D, 64'h1000, 64'h0);
    bus_gnt_i = 1'b1;
    step();
    bus_gnt_i = 1'b0;
    check("rst_wait_busy", req_ready_o, 64'd0);
    rst_n = 1'b0;
    #1;
    check("rst_wait_bus_req", bus_req_o, 64'd0);
    check("rst_wait_resp", resp_valid_o, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rst_wait_release_ready", req_ready_o, 64'd1);
    step();
    check("rst_wait_no_resp", resp_valid_o, 64'd0);

    access(LD_H, 64'h1006, 64'h0, 8'hC0, 64'h0, D0, 1'b0, 0, 64'h0000_0000_0000_0123);

    repeat (3) step();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
